lcd_cmd_scheduler: RTL

//  Sequences and shares the single LCD byte-write controller (start/done handshake) between

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_rr_arbiter.sv | 60 ++++++
 rtl/lcd_cmd_scheduler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command scheduler: FSM states,
// HD44780 command bytes and the power-up init sequence.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_INIT,
        S_START,
        S_WAIT,
        S_GAP,
        S_ARB
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_HOME     = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam int INIT_LEN   = 5;
    localparam int INIT_IDX_W = 3;

    function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
        case (idx)
            3'd0:    init_rom = LCD_FUNC_SET;
            3'd1:    init_rom = LCD_DISP_ON;
            3'd2:    init_rom = LCD_CLEAR;
            3'd3:    init_rom = LCD_ENTRY;
            default: init_rom = LCD_HOME;
        endcase
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin grant among NREQ requesters. While locked only the owner may be
// granted; the pointer moves past a requester when its burst ends.
module lcd_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic                    i_en,
    input  logic                    i_lock,
    input  logic [$clog2(NREQ)-1:0] i_owner,
    input  logic                    i_advance,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_grant_idx,
    output logic                    o_grant_vld
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CW    = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q;
    logic [CW-1:0]    cand;

    always_comb begin
        o_grant_vld = 1'b0;
        o_grant_idx = '0;
        cand        = '0;
        if (i_en) begin
            if (i_lock) begin
                o_grant_vld = i_req[i_owner];
                o_grant_idx = i_owner;
            end else begin
                // First valid requester at or after the pointer, wrapping modulo NREQ.
                for (int off = 0; off < NREQ; off++) begin
                    cand = {1'b0, ptr_q} + CW'(off);
                    if (cand >= CW'(NREQ)) begin
                        cand = cand - CW'(NREQ);
                    end
                    if (!o_grant_vld && i_req[cand[IDX_W-1:0]]) begin
                        o_grant_vld = 1'b1;
                        o_grant_idx = cand[IDX_W-1:0];
                    end
                end
            end
        end
        o_grant = '0;
        if (o_grant_vld) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else if (i_advance) begin
            ptr_q <= (o_grant_idx == IDX_W'(NREQ - 1)) ? '0 : o_grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Shares one LCD byte-write controller between NREQ clients: runs the HD44780
// init sequence after reset, then serves round-robin bursts with a settle gap.
module lcd_cmd_scheduler
    import lcd_pkg::*;
#(
    parameter int               NREQ       = 2,
    parameter int               DLY_W      = 18,
    parameter logic [DLY_W-1:0] DLY_CYCLES = 18'h3FFFE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ-1:0]   i_req_rs,
    input  logic [8*NREQ-1:0] i_req_data,
    input  logic [NREQ-1:0]   i_req_last,
    output logic [NREQ-1:0]   o_req_ready,
    output logic              o_init_done,
    output logic              o_busy,
    output logic [7:0]        o_lcd_data,
    output logic              o_lcd_rs,
    output logic              o_lcd_start,
    input  logic              i_lcd_done
);

    localparam int                    IDX_W     = $clog2(NREQ);
    localparam logic [DLY_W-1:0]      GAP_LAST  = DLY_CYCLES - DLY_W'(1);
    localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);

    lcd_state_e            state_q, state_d;
    logic [INIT_IDX_W-1:0] idx_q;
    logic [DLY_W-1:0]      cnt_q;
    logic [7:0]            data_q;
    logic                  rs_q;
    logic                  lock_q;
    logic [IDX_W-1:0]      owner_q;
    logic                  init_done_q;
    logic                  busy_q;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic             arb_en;
    logic             gap_end;
    logic             acc_last;
    logic             acc_rs;
    logic [7:0]       acc_data;

    assign arb_en   = (state_q == S_ARB) && init_done_q;
    assign gap_end  = (state_q == S_GAP) && (cnt_q == GAP_LAST);
    assign acc_last = i_req_last[grant_idx];
    assign acc_rs   = i_req_rs[grant_idx];
    assign acc_data = i_req_data[8*grant_idx +: 8];

    lcd_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req      (i_req_valid),
        .i_en       (arb_en),
        .i_lock     (lock_q),
        .i_owner    (owner_q),
        .i_advance  (grant_vld && acc_last),
        .o_grant    (grant),
        .o_grant_idx(grant_idx),
        .o_grant_vld(grant_vld)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // A done that arrives while start is first raised already completes the byte.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:         state_d = S_START;
            S_START,
            S_WAIT:         state_d = i_lcd_done ? S_GAP : S_WAIT;
            S_GAP: begin
                if (gap_end) begin
                    state_d = (init_done_q || idx_q == INIT_LAST) ? S_ARB : S_INIT;
                end
            end
            S_ARB: begin
                if (grant_vld) begin
                    state_d = S_START;
                end
            end
            default:        state_d = S_INIT;
        endcase
    end

    always_comb begin
        o_req_ready = grant;
        o_lcd_start = (state_q == S_START) || (state_q == S_WAIT);
        o_busy      = busy_q;
        o_init_done = init_done_q;
        o_lcd_data  = data_q;
        o_lcd_rs    = rs_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            lock_q      <= 1'b0;
            owner_q     <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            busy_q <= (state_d != S_ARB);
            cnt_q  <= (state_q == S_GAP) ? cnt_q + DLY_W'(1) : '0;
            if (gap_end && !init_done_q) begin
                if (idx_q == INIT_LAST) begin
                    init_done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + INIT_IDX_W'(1);
                end
            end
            if (state_q == S_INIT) begin
                data_q <= init_rom(idx_q);
                rs_q   <= 1'b0;
            end else if (grant_vld) begin
                data_q  <= acc_data;
                rs_q    <= acc_rs;
                lock_q  <= !acc_last;
                owner_q <= grant_idx;
            end
        end
    end

endmodule
